csr_trap_sequencer: RTL and testbench
=====================================

Name: csr_trap_sequencer

Overview:
- Sits between the Lagarto Hun core and the M-mode CSR file, and owns the CSR file's single access port.
- Arbitrates that port between ordinary core CSR instructions and hardware trap traffic; trap traffic always has priority.
- On an accepted exception it sequences reads of mtvec/mstatus and writes of mepc/mcause/mtval/mstatus, then issues a PC redirect.
- On an accepted mret it reads mepc/mstatus, restores mstatus, then redirects to mepc.

Parameters:
- XLEN, 32, data/PC width; equals MLEN of the CSR file.

Ports:
- clock_i  in  1  clock.
- reset_ni  in  1  reset, asynchronous, active-low.
- exception_valid_i  in  1  exception request, held until accepted.
- exception_cause_i  in  XLEN  mcause value; bit XLEN-1 = interrupt.
- exception_pc_i  in  XLEN  faulting PC.
- exception_tval_i  in  XLEN  mtval value.
- mret_valid_i  in  1  mret request, held until accepted.
- trap_ready_o  out  1  high in IDLE; a request is accepted when valid && ready.
- core_csr_req_i  in  1  core CSR access request.
- core_csr_address_i  in  12  core CSR address.
- core_csr_command_i  in  csr_command_t  core CSR command.
- core_csr_write_data_i  in  XLEN  core write data.
- core_csr_gnt_o  out  1  core access forwarded this cycle.
- csr_address_o  out  12  to CSR file.
- csr_command_o  out  csr_command_t  to CSR file; NO_COMMAND (2'b00) when idle.
- csr_write_data_o  out  XLEN  to CSR file.
- csr_read_data_i  in  XLEN  from CSR file; registered, valid the cycle after a read is issued.
- redirect_valid_o  out  1  one-cycle PC redirect pulse.
- redirect_pc_o  out  XLEN  redirect target.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except trap_ready_o=1. csr_command_o=NO_COMMAND. Capture registers cleared.
- Reset mid-sequence aborts immediately to IDLE. Any partial CSR writes remain; the core re-raises the request.
- Trap sequence. States are listed with the cycle after acceptance, the CSR command issued and the action taken:
  - IDLE (0): request accepted; latch cause, pc and tval.
  - RD_MTVEC (1): READ_ONLY CSR_MTVEC.
  - RD_MSTATUS (2): READ_ONLY CSR_MSTATUS; capture csr_read_data_i as mtvec at end of cycle.
  - WR_MEPC (3): WRITE_ONLY mepc = {pc[XLEN-1:2],2'b00}; capture mstatus at end of cycle.
  - WR_MCAUSE (4): WRITE_ONLY mcause = cause.
  - WR_MTVAL (5): WRITE_ONLY mtval = tval.
  - WR_MSTATUS (6): WRITE_ONLY mstatus with these updates, all other bits unchanged:
    - MPIE(bit7) = captured MIE(bit3).
    - MIE = 0.
    - MPP[12:11] = 2'b11.
  - REDIRECT (7): redirect_valid_o=1, NO_COMMAND; return to IDLE next cycle.
- Trap target:
  - base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==01 and cause[XLEN-1]==1, target = base + (cause[XLEN-2:0]<<2), truncated to XLEN bits (wraps).
  - Otherwise target = base. mtvec[1:0]==10 or 11 is treated as direct.
- Mret sequence:
  - RD_MEPC (1): READ_ONLY CSR_MEPC.
  - RD_MSTATUS_R (2): READ_ONLY CSR_MSTATUS; capture mepc.
  - WR_MSTATUS_R (3): WRITE_ONLY mstatus = csr_read_data_i with these updates:
    - MIE = MPIE.
    - MPIE = 1.
    - MPP = 2'b00.
  - REDIRECT (4): redirect_pc_o = {mepc[XLEN-1:2],2'b00}.
- redirect_pc_o holds its value until the next redirect.
- Priority, when requests coincide in IDLE:
  - exception over mret. The mret is not accepted and stays pending.
  - mret over core access.
  - core access only when neither trap request is valid.
- Core pass-through: in IDLE with core_csr_req_i && !exception_valid_i && !mret_valid_i:
  - core_csr_gnt_o=1.
  - address, command and write data are forwarded combinationally.
  - The core samples csr_read_data_i the following cycle.
- When the core is not granted, core_csr_gnt_o=0 and the core must hold its request.
- Requests arriving while busy_o=1 are not accepted (trap_ready_o=0) and are not lost if held.
- Back-to-back: a request valid in the IDLE cycle after REDIRECT is accepted in that cycle.

Test Plan:
- Direct trap: mtvec=0x8000_0100, mstatus=0x0000_0008, exception cause=2, pc=0x0000_1236, tval=0xDEAD_BEEF.
  - Required: mepc=0x0000_1234, mcause=2, mtval=0xDEADBEEF, mstatus=0x0000_1880.
  - Required: redirect_valid_o at cycle 7 with pc 0x8000_0100.
- Vectored interrupt: mtvec=0x8000_0101, cause=0x8000_0007 -> redirect_pc_o=0x8000_011C.
- Mret: mepc=0x0000_2000, mstatus=0x0000_1880 -> mstatus=0x0000_0088; redirect 0x0000_2000 at cycle 4.
- Contention: exception, mret and core request all valid in one IDLE cycle.
  - Required: trap sequence runs and core_csr_gnt_o=0 throughout.
  - Required: mret accepted in the IDLE cycle after the trap REDIRECT; core granted only after that mret completes.
- Core pass-through: READ_ONLY CSR_MSCRATCH (mscratch=0x1234_5678) in IDLE -> gnt=1 and forwarded command; data 0x12345678 next cycle.
- Reset asserted in WR_MCAUSE -> immediate IDLE, csr_command_o=NO_COMMAND, busy_o=0, trap_ready_o=1, no redirect pulse.

Source files
------------

// File: rtl/csr_trap_sequencer.sv
// CSR trap sequencer: owns the single access port of the M-mode CSR file and
// shares it between core CSR instructions and hardware trap/mret sequences.
// Trap traffic always wins over the core. Command encoding on the CSR port:
// 2'b00 no command, 2'b01 write only, 2'b10 read only, 2'b11 read-write.
module csr_trap_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clock_i,
   input  logic            reset_ni,
   // Trap requests from the core
   input  logic            exception_valid_i,
   input  logic [XLEN-1:0] exception_cause_i,
   input  logic [XLEN-1:0] exception_pc_i,
   input  logic [XLEN-1:0] exception_tval_i,
   input  logic            mret_valid_i,
   output logic            trap_ready_o,
   // Ordinary core CSR access
   input  logic            core_csr_req_i,
   input  logic [11:0]     core_csr_address_i,
   input  logic [1:0]      core_csr_command_i,
   input  logic [XLEN-1:0] core_csr_write_data_i,
   output logic            core_csr_gnt_o,
   // CSR file access port
   output logic [11:0]     csr_address_o,
   output logic [1:0]      csr_command_o,
   output logic [XLEN-1:0] csr_write_data_o,
   input  logic [XLEN-1:0] csr_read_data_i,
   // PC redirect towards the fetch stage
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            busy_o
);

   localparam logic [1:0] NoCommand = 2'b00;
   localparam logic [1:0] WriteOnly = 2'b01;
   localparam logic [1:0] ReadOnly  = 2'b10;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;
   localparam logic [11:0] CsrMtval   = 12'h343;

   // mstatus field positions
   localparam int unsigned MieBit  = 3;
   localparam int unsigned MpieBit = 7;
   localparam int unsigned MppLo   = 11;
   localparam int unsigned MppHi   = 12;

   typedef enum logic [3:0] {
      StIdle,
      StRdMtvec,
      StRdMstatus,
      StWrMepc,
      StWrMcause,
      StWrMtval,
      StWrMstatus,
      StRedirect,
      StRdMepc,
      StRdMstatusR,
      StWrMstatusR
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic            w_accept_exc;
   logic            w_accept_mret;

   // Trap request captured at acceptance; the core may drop it afterwards.
   logic [XLEN-1:0] r_cause;
   logic [XLEN-3:0] r_pc_word;
   logic [XLEN-1:0] r_tval;

   // CSR values read during a sequence
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mstatus;
   logic [XLEN-3:0] r_mepc_word;

   logic [XLEN-1:0] r_redirect_pc;

   logic [XLEN-1:0] w_trap_base;
   logic            w_vectored;
   logic [XLEN-1:0] w_trap_target;
   logic [XLEN-1:0] w_trap_mstatus;
   logic [XLEN-1:0] w_mret_mstatus;

   // Trap target: direct unless mtvec selects vectored mode and the cause is an interrupt.
   // Modes 2'b10/2'b11 fall back to direct; the vector offset wraps at XLEN bits.
   always_comb begin
      w_trap_base   = {r_mtvec[XLEN-1:2], 2'b00};
      w_vectored    = (r_mtvec[1:0] == 2'b01) && r_cause[XLEN-1];
      w_trap_target = w_trap_base;
      if (w_vectored) begin
         w_trap_target = w_trap_base + {r_cause[XLEN-3:0], 2'b00};
      end
   end

   // mstatus on trap entry: stack MIE into MPIE, disable interrupts, previous mode = M.
   always_comb begin
      w_trap_mstatus              = r_mstatus;
      w_trap_mstatus[MpieBit]     = r_mstatus[MieBit];
      w_trap_mstatus[MieBit]      = 1'b0;
      w_trap_mstatus[MppHi:MppLo] = 2'b11;
   end

   // mstatus on mret: taken straight from the read issued in the previous cycle.
   always_comb begin
      w_mret_mstatus              = csr_read_data_i;
      w_mret_mstatus[MieBit]      = csr_read_data_i[MpieBit];
      w_mret_mstatus[MpieBit]     = 1'b1;
      w_mret_mstatus[MppHi:MppLo] = 2'b00;
   end

   // State register.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, arbitration and CSR port drive.
   always_comb begin
      w_state_next     = r_state;
      w_accept_exc     = 1'b0;
      w_accept_mret    = 1'b0;
      trap_ready_o     = 1'b0;
      busy_o           = 1'b1;
      core_csr_gnt_o   = 1'b0;
      csr_address_o    = 12'h000;
      csr_command_o    = NoCommand;
      csr_write_data_o = '0;
      redirect_valid_o = 1'b0;

      unique case (r_state)
         StIdle: begin
            trap_ready_o = 1'b1;
            busy_o       = 1'b0;
            if (exception_valid_i) begin
               w_accept_exc = 1'b1;
               w_state_next = StRdMtvec;
            end else if (mret_valid_i) begin
               w_accept_mret = 1'b1;
               w_state_next  = StRdMepc;
            end else if (core_csr_req_i) begin
               core_csr_gnt_o   = 1'b1;
               csr_address_o    = core_csr_address_i;
               csr_command_o    = core_csr_command_i;
               csr_write_data_o = core_csr_write_data_i;
            end
         end
         StRdMtvec: begin
            csr_address_o = CsrMtvec;
            csr_command_o = ReadOnly;
            w_state_next  = StRdMstatus;
         end
         StRdMstatus: begin
            csr_address_o = CsrMstatus;
            csr_command_o = ReadOnly;
            w_state_next  = StWrMepc;
         end
         StWrMepc: begin
            csr_address_o    = CsrMepc;
            csr_command_o    = WriteOnly;
            csr_write_data_o = {r_pc_word, 2'b00};
            w_state_next     = StWrMcause;
         end
         StWrMcause: begin
            csr_address_o    = CsrMcause;
            csr_command_o    = WriteOnly;
            csr_write_data_o = r_cause;
            w_state_next     = StWrMtval;
         end
         StWrMtval: begin
            csr_address_o    = CsrMtval;
            csr_command_o    = WriteOnly;
            csr_write_data_o = r_tval;
            w_state_next     = StWrMstatus;
         end
         StWrMstatus: begin
            csr_address_o    = CsrMstatus;
            csr_command_o    = WriteOnly;
            csr_write_data_o = w_trap_mstatus;
            w_state_next     = StRedirect;
         end
         StRdMepc: begin
            csr_address_o = CsrMepc;
            csr_command_o = ReadOnly;
            w_state_next  = StRdMstatusR;
         end
         StRdMstatusR: begin
            csr_address_o = CsrMstatus;
            csr_command_o = ReadOnly;
            w_state_next  = StWrMstatusR;
         end
         StWrMstatusR: begin
            csr_address_o    = CsrMstatus;
            csr_command_o    = WriteOnly;
            csr_write_data_o = w_mret_mstatus;
            w_state_next     = StRedirect;
         end
         StRedirect: begin
            redirect_valid_o = 1'b1;
            w_state_next     = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Latch the exception request on acceptance.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cause   <= '0;
         r_pc_word <= '0;
         r_tval    <= '0;
      end else if (w_accept_exc) begin
         r_cause   <= exception_cause_i;
         r_pc_word <= exception_pc_i[XLEN-1:2];
         r_tval    <= exception_tval_i;
      end
   end

   // Capture read data one cycle after each read was issued.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_mtvec     <= '0;
         r_mstatus   <= '0;
         r_mepc_word <= '0;
      end else begin
         if (r_state == StRdMstatus) begin
            r_mtvec <= csr_read_data_i;
         end
         if (r_state == StWrMepc) begin
            r_mstatus <= csr_read_data_i;
         end
         if (r_state == StRdMstatusR) begin
            r_mepc_word <= csr_read_data_i[XLEN-1:2];
         end
      end
   end

   // Redirect target is loaded on entry to StRedirect and held until the next redirect.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_redirect_pc <= '0;
      end else if (r_state == StWrMstatus) begin
         r_redirect_pc <= w_trap_target;
      end else if (r_state == StWrMstatusR) begin
         r_redirect_pc <= {r_mepc_word, 2'b00};
      end
   end

   assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Testbench for csr_trap_sequencer: a small CSR file stub answers the access port,
// and expected CSR contents / redirect targets come from a behavioural model.
module tb_csr_trap_sequencer;

   localparam int XLEN = 32;

   localparam logic [1:0] CMD_NO = 2'b00;
   localparam logic [1:0] CMD_WR = 2'b01;
   localparam logic [1:0] CMD_RD = 2'b10;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;

   logic            clock_i;
   logic            reset_ni;
   logic            exception_valid_i;
   logic [XLEN-1:0] exception_cause_i;
   logic [XLEN-1:0] exception_pc_i;
   logic [XLEN-1:0] exception_tval_i;
   logic            mret_valid_i;
   logic            trap_ready_o;
   logic            core_csr_req_i;
   logic [11:0]     core_csr_address_i;
   logic [1:0]      core_csr_command_i;
   logic [XLEN-1:0] core_csr_write_data_i;
   logic            core_csr_gnt_o;
   logic [11:0]     csr_address_o;
   logic [1:0]      csr_command_o;
   logic [XLEN-1:0] csr_write_data_o;
   logic [XLEN-1:0] csr_read_data_i;
   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            busy_o;

   int n_assert = 0;
   int n_fail   = 0;

   // Model of architectural CSR state
   logic [31:0] ref_mtvec, ref_mstatus, ref_mepc, ref_mcause, ref_mtval;

   // CSR file stub
   logic [31:0] mem [0:4095];
   logic [31:0] rd_q;
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   csr_trap_sequencer #(.XLEN(XLEN)) dut (
      .clock_i               (clock_i),
      .reset_ni              (reset_ni),
      .exception_valid_i     (exception_valid_i),
      .exception_cause_i     (exception_cause_i),
      .exception_pc_i        (exception_pc_i),
      .exception_tval_i      (exception_tval_i),
      .mret_valid_i          (mret_valid_i),
      .trap_ready_o          (trap_ready_o),
      .core_csr_req_i        (core_csr_req_i),
      .core_csr_address_i    (core_csr_address_i),
      .core_csr_command_i    (core_csr_command_i),
      .core_csr_write_data_i (core_csr_write_data_i),
      .core_csr_gnt_o        (core_csr_gnt_o),
      .csr_address_o         (csr_address_o),
      .csr_command_o         (csr_command_o),
      .csr_write_data_o      (csr_write_data_o),
      .csr_read_data_i       (csr_read_data_i),
      .redirect_valid_o      (redirect_valid_o),
      .redirect_pc_o         (redirect_pc_o),
      .busy_o                (busy_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   // CSR file: writes land at the edge, reads return registered data next cycle.
   always @(posedge clock_i) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (csr_command_o[0]) begin
         mem[csr_address_o] <= csr_write_data_o;
      end
      if (csr_command_o[1]) begin
         rd_q <= mem[csr_address_o];
      end
   end
   assign csr_read_data_i = rd_q;

   function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      logic [31:0] off;
      base = tvec & 32'hFFFF_FFFC;
      off  = (cause & 32'h7FFF_FFFF) * 32'd4;
      if (tvec[1:0] == 2'b01 && cause[31]) return base + off;
      return base;
   endfunction

   function automatic logic [31:0] m_trap_mstatus(input logic [31:0] ms);
      return (ms & ~32'h0000_1888) | 32'h0000_1800 | (ms[3] ? 32'h0000_0080 : 32'h0);
   endfunction

   function automatic logic [31:0] m_mret_mstatus(input logic [31:0] ms);
      return (ms & ~32'h0000_1888) | 32'h0000_0080 | (ms[7] ? 32'h0000_0008 : 32'h0);
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [11:0] addr, input logic [31:0] data);
      @(posedge clock_i); #1;
      pre_we = 1'b1; pre_addr = addr; pre_data = data;
      @(posedge clock_i); #1;
      pre_we = 1'b0;
      case (addr)
         A_MTVEC:   ref_mtvec   = data;
         A_MSTATUS: ref_mstatus = data;
         A_MEPC:    ref_mepc    = data;
         A_MCAUSE:  ref_mcause  = data;
         A_MTVAL:   ref_mtval   = data;
         default:   ;
      endcase
   endtask

   // Raise an exception (optionally together with mret and a core read) and follow the sequence.
   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] tval, input bit contend);
      logic [31:0] e_target, e_ms, e_mepc, e_wd, r;
      logic [1:0]  e_cmd;
      logic [11:0] e_addr;
      e_target = m_target(ref_mtvec, cause);
      e_ms     = m_trap_mstatus(ref_mstatus);
      e_mepc   = pc & 32'hFFFF_FFFC;
      @(posedge clock_i); #1;
      exception_valid_i = 1'b1;
      exception_cause_i = cause;
      exception_pc_i    = pc;
      exception_tval_i  = tval;
      if (contend) begin
         mret_valid_i       = 1'b1;
         core_csr_req_i     = 1'b1;
         core_csr_address_i = A_MSCRATCH;
         core_csr_command_i = CMD_RD;
      end
      @(negedge clock_i);
      check1("trap_accept_ready", trap_ready_o, 1'b1);
      check1("trap_accept_gnt", core_csr_gnt_o, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clock_i); #1;
         if (k == 1) begin
            exception_valid_i = 1'b0;
            r = $urandom; exception_cause_i = r;
            r = $urandom; exception_pc_i    = r;
            r = $urandom; exception_tval_i  = r;
         end
         @(negedge clock_i);
         e_wd = 32'h0;
         case (k)
            1:       begin e_cmd = CMD_RD; e_addr = A_MTVEC;   end
            2:       begin e_cmd = CMD_RD; e_addr = A_MSTATUS; end
            3:       begin e_cmd = CMD_WR; e_addr = A_MEPC;    e_wd = e_mepc; end
            4:       begin e_cmd = CMD_WR; e_addr = A_MCAUSE;  e_wd = cause;  end
            5:       begin e_cmd = CMD_WR; e_addr = A_MTVAL;   e_wd = tval;   end
            6:       begin e_cmd = CMD_WR; e_addr = A_MSTATUS; e_wd = e_ms;   end
            default: begin e_cmd = CMD_NO; e_addr = 12'h000;   end
         endcase
         check32($sformatf("trap_cmd_%0d", k), 32'(csr_command_o), 32'(e_cmd));
         if (k < 7) check32($sformatf("trap_addr_%0d", k), 32'(csr_address_o), 32'(e_addr));
         if (k >= 3 && k <= 6) check32($sformatf("trap_wdata_%0d", k), csr_write_data_o, e_wd);
         check1($sformatf("trap_redirect_valid_%0d", k), redirect_valid_o, k == 7);
         check1($sformatf("trap_busy_%0d", k), busy_o, 1'b1);
         check1($sformatf("trap_ready_low_%0d", k), trap_ready_o, 1'b0);
         check1($sformatf("trap_gnt_low_%0d", k), core_csr_gnt_o, 1'b0);
      end
      check32("trap_redirect_pc", redirect_pc_o, e_target);
      check32("trap_mem_mepc", mem[A_MEPC], e_mepc);
      check32("trap_mem_mcause", mem[A_MCAUSE], cause);
      check32("trap_mem_mtval", mem[A_MTVAL], tval);
      check32("trap_mem_mstatus", mem[A_MSTATUS], e_ms);
      ref_mepc    = e_mepc;
      ref_mcause  = cause;
      ref_mtval   = tval;
      ref_mstatus = e_ms;
   endtask

   // Raise mret in the next cycle and follow the return sequence.
   task automatic do_mret();
      logic [31:0] e_pc, e_ms;
      logic [1:0]  e_cmd;
      logic [11:0] e_addr;
      e_pc = ref_mepc & 32'hFFFF_FFFC;
      e_ms = m_mret_mstatus(ref_mstatus);
      @(posedge clock_i); #1;
      mret_valid_i = 1'b1;
      @(negedge clock_i);
      check1("mret_accept_ready", trap_ready_o, 1'b1);
      check1("mret_accept_gnt", core_csr_gnt_o, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock_i); #1;
         if (k == 1) mret_valid_i = 1'b0;
         @(negedge clock_i);
         case (k)
            1:       begin e_cmd = CMD_RD; e_addr = A_MEPC;    end
            2:       begin e_cmd = CMD_RD; e_addr = A_MSTATUS; end
            3:       begin e_cmd = CMD_WR; e_addr = A_MSTATUS; end
            default: begin e_cmd = CMD_NO; e_addr = 12'h000;   end
         endcase
         check32($sformatf("mret_cmd_%0d", k), 32'(csr_command_o), 32'(e_cmd));
         if (k < 4) check32($sformatf("mret_addr_%0d", k), 32'(csr_address_o), 32'(e_addr));
         if (k == 3) check32("mret_wdata", csr_write_data_o, e_ms);
         check1($sformatf("mret_redirect_valid_%0d", k), redirect_valid_o, k == 4);
         check1($sformatf("mret_busy_%0d", k), busy_o, 1'b1);
         check1($sformatf("mret_gnt_low_%0d", k), core_csr_gnt_o, 1'b0);
      end
      check32("mret_redirect_pc", redirect_pc_o, e_pc);
      check32("mret_mem_mstatus", mem[A_MSTATUS], e_ms);
      ref_mstatus = e_ms;
   endtask

   // One core access in IDLE; reads are checked against exp_rd the following cycle.
   task automatic core_access(input logic [1:0] cmd, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd);
      @(posedge clock_i); #1;
      core_csr_req_i        = 1'b1;
      core_csr_address_i    = addr;
      core_csr_command_i    = cmd;
      core_csr_write_data_i = wdata;
      @(negedge clock_i);
      check1("core_gnt", core_csr_gnt_o, 1'b1);
      check32("core_fwd_cmd", 32'(csr_command_o), 32'(cmd));
      check32("core_fwd_addr", 32'(csr_address_o), 32'(addr));
      check32("core_fwd_wdata", csr_write_data_o, wdata);
      check1("core_busy", busy_o, 1'b0);
      @(posedge clock_i); #1;
      core_csr_req_i = 1'b0;
      @(negedge clock_i);
      check1("core_gnt_drop", core_csr_gnt_o, 1'b0);
      if (cmd == CMD_RD) check32("core_rdata", csr_read_data_i, exp_rd);
      else check32("core_mem_write", mem[addr], wdata);
   endtask

   initial begin
      logic [31:0] r, old_mcause;
      exception_valid_i     = 1'b0;
      exception_cause_i     = '0;
      exception_pc_i        = '0;
      exception_tval_i      = '0;
      mret_valid_i          = 1'b0;
      core_csr_req_i        = 1'b0;
      core_csr_address_i    = '0;
      core_csr_command_i    = CMD_NO;
      core_csr_write_data_i = '0;
      pre_we   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      reset_ni = 1'b1;
      #1 reset_ni = 1'b0;
      #2;
      check1("rst_ready", trap_ready_o, 1'b1);
      check1("rst_busy", busy_o, 1'b0);
      check1("rst_redirect", redirect_valid_o, 1'b0);
      check1("rst_gnt", core_csr_gnt_o, 1'b0);
      check32("rst_cmd", 32'(csr_command_o), 32'(CMD_NO));
      check32("rst_redirect_pc", redirect_pc_o, 32'h0);
      @(posedge clock_i); @(posedge clock_i); #1;
      reset_ni = 1'b1;

      preload(A_MEPC, 32'h0);
      preload(A_MCAUSE, 32'h0);
      preload(A_MTVAL, 32'h0);
      preload(A_MSCRATCH, 32'h1234_5678);

      // Direct trap
      preload(A_MTVEC, 32'h8000_0100);
      preload(A_MSTATUS, 32'h0000_0008);
      do_trap(32'h2, 32'h0000_1236, 32'hDEAD_BEEF, 1'b0);
      check32("direct_mepc", mem[A_MEPC], 32'h0000_1234);
      check32("direct_mcause", mem[A_MCAUSE], 32'h2);
      check32("direct_mtval", mem[A_MTVAL], 32'hDEAD_BEEF);
      check32("direct_mstatus", mem[A_MSTATUS], 32'h0000_1880);
      check32("direct_target", redirect_pc_o, 32'h8000_0100);
      @(negedge clock_i);
      check1("redirect_one_cycle", redirect_valid_o, 1'b0);
      check32("redirect_pc_held", redirect_pc_o, 32'h8000_0100);

      // Vectored interrupt
      preload(A_MTVEC, 32'h8000_0101);
      do_trap(32'h8000_0007, 32'h0000_0400, 32'h0, 1'b0);
      check32("vectored_target", redirect_pc_o, 32'h8000_011C);

      // Mret
      preload(A_MEPC, 32'h0000_2000);
      preload(A_MSTATUS, 32'h0000_1880);
      do_mret();
      check32("mret_mstatus", mem[A_MSTATUS], 32'h0000_0088);
      check32("mret_target", redirect_pc_o, 32'h0000_2000);

      // Contention: exception, mret and core read raised together
      preload(A_MTVEC, 32'h8000_0200);
      preload(A_MSTATUS, 32'h0000_0008);
      do_trap(32'hB, 32'h0000_3000, 32'h11, 1'b1);
      do_mret();
      check32("contend_mret_target", redirect_pc_o, 32'h0000_3000);
      @(negedge clock_i);
      check1("contend_core_gnt", core_csr_gnt_o, 1'b1);
      check32("contend_core_cmd", 32'(csr_command_o), 32'(CMD_RD));
      @(posedge clock_i); #1;
      core_csr_req_i = 1'b0;

      // Core pass-through
      core_access(CMD_RD, A_MSCRATCH, 32'h0, 32'h1234_5678);
      core_access(CMD_WR, A_MSCRATCH, 32'hCAFE_F00D, 32'h0);
      core_access(CMD_RD, A_MSCRATCH, 32'h0, 32'hCAFE_F00D);

      // Reset during the mcause write
      old_mcause = ref_mcause;
      @(posedge clock_i); #1;
      exception_valid_i = 1'b1;
      exception_cause_i = 32'h5;
      exception_pc_i    = 32'h0000_4002;
      exception_tval_i  = 32'h55;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock_i); #1;
         if (k == 1) exception_valid_i = 1'b0;
      end
      check32("rstmid_pre_cmd", 32'(csr_command_o), 32'(CMD_WR));
      check32("rstmid_pre_addr", 32'(csr_address_o), 32'(A_MCAUSE));
      reset_ni = 1'b0;
      #1;
      check32("rstmid_cmd", 32'(csr_command_o), 32'(CMD_NO));
      check1("rstmid_busy", busy_o, 1'b0);
      check1("rstmid_ready", trap_ready_o, 1'b1);
      check1("rstmid_redirect", redirect_valid_o, 1'b0);
      check32("rstmid_redirect_pc", redirect_pc_o, 32'h0);
      @(posedge clock_i); #1;
      reset_ni = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock_i);
         check1("rstmid_no_redirect", redirect_valid_o, 1'b0);
         check1("rstmid_idle", busy_o, 1'b0);
      end
      check32("rstmid_mepc_kept", mem[A_MEPC], 32'h0000_4000);
      check32("rstmid_mcause_untouched", mem[A_MCAUSE], old_mcause);
      ref_mepc = 32'h0000_4000;

      // Random traps and returns
      for (int i = 0; i < 12; i++) begin
         logic [31:0] c, p, t;
         r = $urandom;
         r[1:0] = 2'($urandom_range(0, 3));
         preload(A_MTVEC, r);
         r = $urandom;
         preload(A_MSTATUS, r);
         c = $urandom;
         p = $urandom;
         t = $urandom;
         do_trap(c, p, t, 1'b0);
         if ($urandom_range(0, 1) == 1) do_mret();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
